fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Parametrised instruction-fetch front end for the pipelined RV32 core; replaces the fixed zero-latency IMemory+pc_f stage.
//  Issues fetch requests over a valid/ready port with variable response latency, keeps up to MAX_OUTSTANDING requests
//  in flight, and buffers returned instructions with their PC in a DEPTH-entry FIFO.
//  Decode pops the FIFO through a valid/ready handshake. Execute redirects fetch on taken branch/jump, and stale responses are discarded.
// PARAMETERS
//  XLEN             32  PC/address width
//  RESET_PC         0   first fetch address after reset
//  DEPTH            4   instruction FIFO entries (power of 2, >=2)
//  MAX_OUTSTANDING  2   max accepted-but-unanswered requests (1..DEPTH)
// PORTS
//  clk             in   1     clock, rising edge
//  rst_n           in   1     asynchronous active-low reset
//  imem_req_valid  out  1     fetch request valid
//  imem_req_ready  in   1     memory accepts request
//  imem_req_addr   out  XLEN  fetch address, bits[1:0]=0
//  imem_rsp_valid  in   1     instruction returned (in order, no backpressure)
//  imem_rsp_data   in   32    returned instruction
//  redirect_valid  in   1     execute-stage redirect (pc_src_e)
//  redirect_pc     in   XLEN  redirect target (pc_target_e); bits[1:0] forced 0
//  out_valid       out  1     FIFO head valid
//  out_ready       in   1     decode accepts head (!stall_d)
//  out_instr       out  32    head instruction
//  out_pc          out  XLEN  head PC
//  out_pc_plus_4   out  XLEN  head PC+4, modulo 2^XLEN
// BEHAVIOUR
//  Reset (async assert, sync deassert):
//   - fetch_pc=RESET_PC; FIFO empty; outstanding=0; drop_cnt=0.
//   - imem_req_valid=0; out_valid=0; out_instr/out_pc/out_pc_plus_4=0.
//  Request issue:
//   - imem_req_valid=1 iff outstanding<MAX_OUTSTANDING and (occupancy+outstanding)<DEPTH, plus reset inactive.
//   - The credit rule makes FIFO overflow impossible.
//   - imem_req_valid is registered-state only; it never depends combinationally on redirect_valid or out_ready.
//   - imem_req_addr=fetch_pc, held stable while valid&&!ready.
//   - On handshake: fetch_pc+=4 (wraps); outstanding+1; the PC is pushed into an in-flight PC queue (MAX_OUTSTANDING deep).
//  Response:
//   - A response arrives no earlier than the cycle after its acceptance.
//   - If drop_cnt>0: discard it, drop_cnt-1, outstanding-1.
//   - Else: push {instr, pc} into the FIFO, pop the in-flight PC queue, outstanding-1.
//   - Response with outstanding==0 is a protocol error and is ignored.
//  Output:
//   - out_valid = FIFO not empty (registered storage).
//   - A response is visible on out_* the cycle after imem_rsp_valid; no same-cycle bypass.
//   - Pop on out_valid&&out_ready. Push and pop in the same cycle are allowed, including when full or 1-entry.
//  Redirect (redirect_valid=1 at edge):
//   - FIFO emptied; out_valid=0 next cycle. A pop in the redirect cycle still completes.
//   - fetch_pc=redirect_pc; in-flight PC queue cleared.
//   - drop_cnt=outstanding_next, counting a request accepted in the same cycle but excluding a response consumed in the same cycle.
//   - Any response in the redirect cycle is discarded.
//   - Back-to-back redirects: the last one wins, and drop counts accumulate correctly.
//   - Redirect while drop_cnt>0: the new drop_cnt covers all still-unanswered requests.
//  Latency:
//   - Redirect at cycle N: request at N+1. With zero-wait memory, rsp at N+2, out_valid at N+3.
//   - Steady state: 1 instr/cycle when imem_req_ready=1, 1-cycle latency, MAX_OUTSTANDING>=2, DEPTH>=3.
//  Invariants: occupancy+outstanding<=DEPTH; drop_cnt<=outstanding<=MAX_OUTSTANDING.
// TESTING
//  1. Zero-wait memory, rsp_data=addr, out_ready=1: out_pc=0,4,8,... one per cycle from cycle 3; out_instr==out_pc.
//  2. out_ready=0 for 10 cycles: FIFO holds 4 entries (pc 0..0xC), req_valid=0, outstanding=0. Release: 0,4,8,0xC then 0x10, none lost or duplicated.
//  3. Two requests outstanding, redirect to 0x100: both late responses dropped; next out_pc=0x100, out_pc_plus_4=0x104.
//  4. Redirect coincident with a req handshake and a response: all three stale instrs discarded; first output is redirect target; counters return to 0.
//  5. Random imem_req_ready (50%), rsp latency 1-3, random out_ready and redirects: output stream matches a scoreboard PC model exactly.
//  6. rst_n low mid-burst (async, between edges): out_valid and req_valid 0 immediately; after release, the first request is RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: credit-limited request issue, in-order response capture,
// stale-response dropping after redirects, and a DEPTH-entry {instr, pc} FIFO toward decode.
module fetch_unit #(
   parameter int              XLEN            = 32,
   parameter logic [XLEN-1:0] RESET_PC        = '0,
   parameter int              DEPTH           = 4,
   parameter int              MAX_OUTSTANDING = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_instr,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_pc_plus_4
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

   logic            active;
   logic [XLEN-1:0] fetch_pc;
   logic [OW-1:0]   outstanding;
   logic [OW-1:0]   drop_cnt;
   logic [OW-1:0]   outstanding_next;

   logic [XLEN-1:0] ifq_pc [MAX_OUTSTANDING];
   logic [QW-1:0]   ifq_wr;
   logic [QW-1:0]   ifq_rd;

   logic [31:0]     fifo_instr [DEPTH];
   logic [XLEN-1:0] fifo_pc    [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;

   logic [CW:0]     credit_used;
   logic [XLEN-1:0] redirect_target;
   logic            req_fire;
   logic            rsp_fire;
   logic            rsp_keep;
   logic            pop;

   function automatic logic [QW-1:0] ifq_inc(input logic [QW-1:0] p);
      return (p == QW'(MAX_OUTSTANDING - 1)) ? '0 : p + QW'(1);
   endfunction

   // Request credit counts both buffered entries and unanswered requests, so the FIFO can never overflow.
   assign credit_used     = (CW + 1)'(count) + (CW + 1)'(outstanding);
   assign imem_req_valid  = active && (outstanding < OW'(MAX_OUTSTANDING))
                                   && (credit_used < (CW + 1)'(DEPTH));
   assign imem_req_addr   = fetch_pc;
   assign redirect_target = redirect_pc & ~XLEN'(3);

   assign req_fire = imem_req_valid && imem_req_ready;
   assign rsp_fire = imem_rsp_valid && (outstanding != '0);
   assign rsp_keep = rsp_fire && (drop_cnt == '0) && !redirect_valid;
   assign pop      = out_valid && out_ready;

   assign outstanding_next = outstanding + OW'(req_fire) - OW'(rsp_fire);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active      <= 1'b0;
         fetch_pc    <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         active      <= 1'b1;
         outstanding <= outstanding_next;
         if (redirect_valid) begin
            fetch_pc <= redirect_target;
            drop_cnt <= outstanding_next;
         end else begin
            if (req_fire)
               fetch_pc <= fetch_pc + PC_STEP;
            if (rsp_fire && (drop_cnt != '0))
               drop_cnt <= drop_cnt - OW'(1);
         end
      end
   end

   // PCs of live (non-dropped) requests, in issue order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ifq_wr <= '0;
         ifq_rd <= '0;
      end else if (redirect_valid) begin
         ifq_wr <= '0;
         ifq_rd <= '0;
      end else begin
         if (req_fire)
            ifq_wr <= ifq_inc(ifq_wr);
         if (rsp_keep)
            ifq_rd <= ifq_inc(ifq_rd);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (redirect_valid) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (rsp_keep)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(rsp_keep) - CW'(pop);
      end
   end

   // NOTE: storage arrays carry no reset; pointers and counts define validity and outputs are gated by out_valid.
   always_ff @(posedge clk) begin
      if (req_fire && !redirect_valid)
         ifq_pc[ifq_wr] <= fetch_pc;
      if (rsp_keep) begin
         fifo_instr[wr_ptr] <= imem_rsp_data;
         fifo_pc[wr_ptr]    <= ifq_pc[ifq_rd];
      end
   end

   assign out_valid     = (count != '0);
   assign out_instr     = out_valid ? fifo_instr[rd_ptr] : '0;
   assign out_pc        = out_valid ? fifo_pc[rd_ptr] : '0;
   assign out_pc_plus_4 = out_valid ? fifo_pc[rd_ptr] + PC_STEP : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a latency-randomising memory model plus a sequential-PC
// scoreboard for requests and the decode stream, driven through directed and random phases.
module tb_fetch_unit;

   localparam int          XLEN     = 32;
   localparam int          DEPTH    = 4;
   localparam int          MAXO     = 2;
   localparam logic [31:0] RESET_PC = 32'h0;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [31:0] out_pc_plus_4;

   always #5 clk = ~clk;

   fetch_unit #(
      .XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_pc(out_pc), .out_pc_plus_4(out_pc_plus_4)
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mem_req_t;

   int          total = 0;
   int          bad = 0;
   mem_req_t    pend[$];
   int          cyc = 0;
   int          last_due = -1;
   int          pops = 0;
   logic [31:0] exp_pc = RESET_PC;
   logic [31:0] exp_fetch = RESET_PC;
   int          ready_pct = 100;
   int          oready_pct = 100;
   int          redir_pct = 0;
   int          lat_min = 1;
   int          lat_max = 1;
   bit          redir_force = 1'b0;
   logic [31:0] redir_target = '0;
   bit          prev_stall = 1'b0;
   logic [31:0] prev_addr = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs after the falling edge, sample, advance the model at the rising edge.
   task automatic cycle();
      bit          rsp, redir, hs, pop, req_v;
      logic [31:0] tgt, addr, o_pc, o_instr, o_pc4;
      int          lat, due;
      rsp = (pend.size() > 0) && (pend[0].due == cyc);
      imem_rsp_valid = rsp;
      imem_rsp_data  = rsp ? pend[0].addr : $urandom;
      imem_req_ready = int'($urandom_range(99)) < ready_pct;
      out_ready      = int'($urandom_range(99)) < oready_pct;
      redir          = redir_force || (int'($urandom_range(99)) < redir_pct);
      tgt            = redir_force ? redir_target : ($urandom & 32'h0000_0FFF);
      redirect_valid = redir;
      redirect_pc    = tgt;
      redir_force    = 1'b0;
      #1;
      req_v   = imem_req_valid;
      addr    = imem_req_addr;
      hs      = imem_req_valid && imem_req_ready;
      pop     = out_valid && out_ready;
      o_pc    = out_pc;
      o_instr = out_instr;
      o_pc4   = out_pc_plus_4;
      if (prev_stall) begin
         check("req_hold_valid", 32'(req_v), 32'd1);
         check("req_hold_addr", addr, prev_addr);
      end
      @(posedge clk);
      if (hs) begin
         check("req_credit", 32'(pend.size() < MAXO), 32'd1);
         check("req_addr", addr, exp_fetch);
         exp_fetch = exp_fetch + 32'd4;
      end
      if (rsp)
         void'(pend.pop_front());
      if (hs) begin
         lat = $urandom_range(lat_max, lat_min);
         due = cyc + lat;
         if (due <= last_due)
            due = last_due + 1;
         pend.push_back('{addr: addr, due: due});
         last_due = due;
      end
      if (pop) begin
         check("out_pc", o_pc, exp_pc);
         check("out_instr", o_instr, exp_pc);
         check("out_pc_plus_4", o_pc4, exp_pc + 32'd4);
         exp_pc = exp_pc + 32'd4;
         pops++;
      end
      if (redir) begin
         exp_pc    = tgt & ~32'd3;
         exp_fetch = tgt & ~32'd3;
      end
      prev_stall = req_v && !imem_req_ready && !redir;
      prev_addr  = addr;
      @(negedge clk);
      cyc++;
   endtask

   // Asynchronous assertion between edges; release just after a falling edge.
   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_out_valid", 32'(out_valid), 32'd0);
      check("rst_async_req_valid", 32'(imem_req_valid), 32'd0);
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      redirect_valid = 1'b0;
      out_ready      = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_instr", out_instr, 32'd0);
      check("rst_out_pc", out_pc, 32'd0);
      check("rst_out_pc_plus_4", out_pc_plus_4, 32'd0);
      rst_n = 1'b1;
      pend.delete();
      last_due   = -1;
      cyc        = 0;
      exp_pc     = RESET_PC;
      exp_fetch  = RESET_PC;
      prev_stall = 1'b0;
   endtask

   task automatic wait_out_valid(input int max_cycles);
      int n;
      n = 0;
      while (!out_valid && n < max_cycles) begin
         cycle();
         n++;
      end
      check("wait_out_valid", 32'(out_valid), 32'd1);
   endtask

   task automatic set_mode(input int rdy, input int ordy, input int rdr, input int lmin, input int lmax);
      ready_pct  = rdy;
      oready_pct = ordy;
      redir_pct  = rdr;
      lat_min    = lmin;
      lat_max    = lmax;
   endtask

   // Stall decode until the credit limit stops fetch, then drain DEPTH back-to-back entries.
   task automatic fill_and_drain(input logic [31:0] base);
      set_mode(100, 0, 0, 1, 1);
      repeat (10) cycle();
      check("fill_req_valid", 32'(imem_req_valid), 32'd0);
      check("fill_outstanding", 32'(pend.size()), 32'd0);
      check("fill_out_valid", 32'(out_valid), 32'd1);
      oready_pct = 100;
      for (int i = 0; i < DEPTH; i++) begin
         check("drain_valid", 32'(out_valid), 32'd1);
         check("drain_pc", out_pc, base + 32'(4 * i));
         cycle();
      end
      wait_out_valid(10);
      check("drain_next_pc", out_pc, base + 32'(4 * DEPTH));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      logic [31:0] base;

      // Reset state, then zero-wait streaming from the reset PC.
      set_mode(100, 100, 0, 1, 1);
      do_reset();
      check("c0_req_valid", 32'(imem_req_valid), 32'd0);
      cycle();
      check("c1_req_valid", 32'(imem_req_valid), 32'd1);
      check("c1_req_addr", imem_req_addr, RESET_PC);
      cycle();
      check("c2_out_valid", 32'(out_valid), 32'd0);
      cycle();
      for (int i = 0; i < 8; i++) begin
         check("stream_valid", 32'(out_valid), 32'd1);
         check("stream_pc", out_pc, RESET_PC + 32'(4 * i));
         cycle();
      end

      // Decode stall fills the FIFO from reset, then releases in order.
      do_reset();
      fill_and_drain(RESET_PC);

      // Two requests in flight at redirect: both late responses are dropped.
      do_reset();
      set_mode(100, 100, 0, 3, 3);
      repeat (3) cycle();
      check("t3_req_capped", 32'(imem_req_valid), 32'd0);
      check("t3_inflight", 32'(pend.size()), 32'd2);
      redir_force  = 1'b1;
      redir_target = 32'h0000_0100;
      cycle();
      wait_out_valid(20);
      check("t3_out_pc", out_pc, 32'h0000_0100);
      check("t3_out_pc_plus_4", out_pc_plus_4, 32'h0000_0104);
      check("t3_out_instr", out_instr, 32'h0000_0100);

      // Redirect coinciding with a request handshake and a response, with unaligned target.
      do_reset();
      set_mode(100, 100, 0, 1, 1);
      repeat (6) cycle();
      check("t4_req_valid", 32'(imem_req_valid), 32'd1);
      check("t4_rsp_due", 32'(pend.size() > 0 && pend[0].due == cyc), 32'd1);
      redir_force  = 1'b1;
      redir_target = 32'h0000_0202;
      cycle();
      check("t4_n1_out_valid", 32'(out_valid), 32'd0);
      check("t4_n1_req_valid", 32'(imem_req_valid), 32'd1);
      check("t4_n1_req_addr", imem_req_addr, 32'h0000_0200);
      cycle();
      check("t4_n2_out_valid", 32'(out_valid), 32'd0);
      cycle();
      check("t4_n3_out_valid", 32'(out_valid), 32'd1);
      check("t4_n3_out_pc", out_pc, 32'h0000_0200);
      base = exp_pc;
      fill_and_drain(base);

      // Random ready, latency, decode stall and redirects against the scoreboard.
      set_mode(50, 60, 3, 1, 3);
      n0 = pops;
      repeat (3000) cycle();
      check("t5_progress", 32'(pops - n0 > 200), 32'd1);

      // Asynchronous reset in the middle of a burst.
      set_mode(100, 100, 0, 1, 1);
      repeat (6) cycle();
      check("t6_pre_req_valid", 32'(imem_req_valid), 32'd1);
      check("t6_pre_out_valid", 32'(out_valid), 32'd1);
      do_reset();
      cycle();
      check("t6_req_valid", 32'(imem_req_valid), 32'd1);
      check("t6_req_addr", imem_req_addr, RESET_PC);
      wait_out_valid(10);
      check("t6_out_pc", out_pc, RESET_PC);
      repeat (10) cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
